// File: rtl/scr1_tb_instr_trig_ctrl.sv
// scr1_tb_instr_trig_ctrl: programmable instruction-trigger capture controller.
// Retiring instructions are compared against mask/match triggers. A hit snapshots
// pc/instr/mstatus/mtvec/mcycle into a small FIFO. The FIFO head is drained over a
// valid/ready log port. An arm/stop/flush sequencer gates when captures happen.
module scr1_tb_instr_trig_ctrl #(
   parameter int NUM_TRIG   = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int XLEN       = 32,
   parameter int CNT_W      = 64,
   localparam int TIW       = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1,
   localparam int AW        = $clog2(FIFO_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctrl_arm,
   input  logic             ctrl_stop,
   input  logic             cfg_we,
   input  logic [TIW-1:0]   cfg_idx,
   input  logic             cfg_en,
   input  logic [XLEN-1:0]  cfg_match,
   input  logic [XLEN-1:0]  cfg_mask,
   input  logic             instr_vld,
   input  logic [XLEN-1:0]  instr,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  csr_mstatus,
   input  logic [XLEN-1:0]  csr_mtvec,
   input  logic [CNT_W-1:0] csr_mcycle,
   output logic             log_vld,
   input  logic             log_rdy,
   output logic [TIW-1:0]   log_trig_id,
   output logic [XLEN-1:0]  log_pc,
   output logic [XLEN-1:0]  log_instr,
   output logic [XLEN-1:0]  log_mstatus,
   output logic [XLEN-1:0]  log_mtvec,
   output logic [CNT_W-1:0] log_mcycle,
   output logic [15:0]      ovf_cnt,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      ST_DISABLED = 2'b00,
      ST_ARMED    = 2'b01,
      ST_FLUSH    = 2'b10
   } state_e;

   state_e state_q, state_d;

   // Trigger configuration
   logic [NUM_TRIG-1:0] trig_en_q;
   logic [XLEN-1:0]     trig_match_q [NUM_TRIG];
   logic [XLEN-1:0]     trig_mask_q  [NUM_TRIG];

   // Capture FIFO storage and pointers (extra MSB is the wrap bit)
   logic [TIW-1:0]   fifo_id_q      [FIFO_DEPTH];
   logic [XLEN-1:0]  fifo_pc_q      [FIFO_DEPTH];
   logic [XLEN-1:0]  fifo_instr_q   [FIFO_DEPTH];
   logic [XLEN-1:0]  fifo_mstatus_q [FIFO_DEPTH];
   logic [XLEN-1:0]  fifo_mtvec_q   [FIFO_DEPTH];
   logic [CNT_W-1:0] fifo_mcycle_q  [FIFO_DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;

   logic [15:0]      ovf_q;

   logic             hit_any_s;
   logic [TIW-1:0]   win_id_s;
   logic             cfg_ok_s;
   logic             empty_s;
   logic             full_s;
   logic [AW:0]      occ_s;
   logic             push_req_s;
   logic             push_s;
   logic             pop_s;
   logic             drop_s;
   logic             flush_done_s;
   logic             ovf_clr_s;

   assign cfg_ok_s = (int'(cfg_idx) < NUM_TRIG);

   // Trigger configuration registers; writable in every state, visible next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_en_q <= '0;
         for (int i = 0; i < NUM_TRIG; i++) begin
            trig_match_q[i] <= '0;
            trig_mask_q[i]  <= '0;
         end
      end else if (cfg_we && cfg_ok_s) begin
         trig_en_q[cfg_idx]    <= cfg_en;
         trig_match_q[cfg_idx] <= cfg_match;
         trig_mask_q[cfg_idx]  <= cfg_mask;
      end
   end

   // Mask/match compare of the current instruction; lowest-index hit wins.
   always_comb begin
      hit_any_s = 1'b0;
      win_id_s  = '0;
      for (int i = NUM_TRIG - 1; i >= 0; i--) begin
         if (trig_en_q[i] && (((instr ^ trig_match_q[i]) & trig_mask_q[i]) == '0)) begin
            hit_any_s = 1'b1;
            win_id_s  = TIW'(i);
         end else begin
            hit_any_s = hit_any_s;
         end
      end
   end

   assign empty_s = (wr_ptr_q == rd_ptr_q);
   assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign occ_s   = wr_ptr_q - rd_ptr_q;

   // Push/pop/drop decisions. A stop in the same cycle suppresses the capture,
   // and a pop frees the slot that a simultaneous push into a full FIFO reuses.
   always_comb begin
      push_req_s   = (state_q == ST_ARMED) && instr_vld && !ctrl_stop && hit_any_s;
      pop_s        = !empty_s && log_rdy;
      push_s       = push_req_s && (!full_s || pop_s);
      drop_s       = push_req_s && full_s && !pop_s;
      flush_done_s = empty_s || (pop_s && (occ_s == {{AW{1'b0}}, 1'b1}));
   end

   // Capture FIFO record storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_id_q[i]      <= '0;
            fifo_pc_q[i]      <= '0;
            fifo_instr_q[i]   <= '0;
            fifo_mstatus_q[i] <= '0;
            fifo_mtvec_q[i]   <= '0;
            fifo_mcycle_q[i]  <= '0;
         end
      end else if (push_s) begin
         fifo_id_q[wr_ptr_q[AW-1:0]]      <= win_id_s;
         fifo_pc_q[wr_ptr_q[AW-1:0]]      <= pc;
         fifo_instr_q[wr_ptr_q[AW-1:0]]   <= instr;
         fifo_mstatus_q[wr_ptr_q[AW-1:0]] <= csr_mstatus;
         fifo_mtvec_q[wr_ptr_q[AW-1:0]]   <= csr_mtvec;
         fifo_mcycle_q[wr_ptr_q[AW-1:0]]  <= csr_mcycle;
      end
   end

   // FIFO read/write pointers, wrapping with an extra bit for full/empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Saturating count of captures dropped on a full FIFO; cleared on arming.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 16'h0000;
      end else if (ovf_clr_s) begin
         ovf_q <= 16'h0000;
      end else if (drop_s && (ovf_q != 16'hFFFF)) begin
         ovf_q <= ovf_q + 16'h0001;
      end
   end

   // Sequencer next state: arm has priority in DISABLED, stop in ARMED,
   // FLUSH exits once the FIFO is (or becomes) empty.
   always_comb begin
      state_d   = state_q;
      ovf_clr_s = 1'b0;
      case (state_q)
         ST_DISABLED: begin
            if (ctrl_arm) begin
               state_d   = ST_ARMED;
               ovf_clr_s = 1'b1;
            end else begin
               state_d   = ST_DISABLED;
            end
         end
         ST_ARMED: begin
            if (ctrl_stop) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_ARMED;
            end
         end
         ST_FLUSH: begin
            if (flush_done_s) begin
               state_d = ST_DISABLED;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         default: begin
            state_d = ST_DISABLED;
         end
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_DISABLED;
      end else begin
         state_q <= state_d;
      end
   end

   assign log_vld     = !empty_s;
   assign log_trig_id = fifo_id_q[rd_ptr_q[AW-1:0]];
   assign log_pc      = fifo_pc_q[rd_ptr_q[AW-1:0]];
   assign log_instr   = fifo_instr_q[rd_ptr_q[AW-1:0]];
   assign log_mstatus = fifo_mstatus_q[rd_ptr_q[AW-1:0]];
   assign log_mtvec   = fifo_mtvec_q[rd_ptr_q[AW-1:0]];
   assign log_mcycle  = fifo_mcycle_q[rd_ptr_q[AW-1:0]];
   assign ovf_cnt     = ovf_q;
   assign state       = state_q;

endmodule

// File: tb/tb_scr1_tb_instr_trig_ctrl.sv
// Directed self-checking bench for scr1_tb_instr_trig_ctrl.
module tb_scr1_tb_instr_trig_ctrl;

   localparam logic [31:0] SUB_I   = 32'h402081B3;
   localparam logic [31:0] ADD_I   = 32'h002081B3;
   localparam logic [31:0] SUB_M   = 32'h40000033;
   localparam logic [31:0] SUB_K   = 32'hFE00707F;

   logic        clk;
   logic        rst;
   logic        ctrl_arm;
   logic        ctrl_stop;
   logic        cfg_we;
   logic [1:0]  cfg_idx;
   logic        cfg_en;
   logic [31:0] cfg_match;
   logic [31:0] cfg_mask;
   logic        instr_vld;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] csr_mstatus;
   logic [31:0] csr_mtvec;
   logic [63:0] csr_mcycle;
   logic        log_vld;
   logic        log_rdy;
   logic [1:0]  log_trig_id;
   logic [31:0] log_pc;
   logic [31:0] log_instr;
   logic [31:0] log_mstatus;
   logic [31:0] log_mtvec;
   logic [63:0] log_mcycle;
   logic [15:0] ovf_cnt;
   logic [1:0]  state;

   int checks;
   int errors;

   scr1_tb_instr_trig_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .ctrl_arm    (ctrl_arm),
      .ctrl_stop   (ctrl_stop),
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_en      (cfg_en),
      .cfg_match   (cfg_match),
      .cfg_mask    (cfg_mask),
      .instr_vld   (instr_vld),
      .instr       (instr),
      .pc          (pc),
      .csr_mstatus (csr_mstatus),
      .csr_mtvec   (csr_mtvec),
      .csr_mcycle  (csr_mcycle),
      .log_vld     (log_vld),
      .log_rdy     (log_rdy),
      .log_trig_id (log_trig_id),
      .log_pc      (log_pc),
      .log_instr   (log_instr),
      .log_mstatus (log_mstatus),
      .log_mtvec   (log_mtvec),
      .log_mcycle  (log_mcycle),
      .ovf_cnt     (ovf_cnt),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // advance one clock and settle just after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [1:0] idx, input logic en,
                      input logic [31:0] m, input logic [31:0] k);
      cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_match = m; cfg_mask = k;
      cyc();
      cfg_we = 1'b0;
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] p, input logic [63:0] mc);
      instr_vld = 1'b1; instr = ins; pc = p; csr_mcycle = mc;
      cyc();
      instr_vld = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; ctrl_arm = 1'b0; ctrl_stop = 1'b0;
      cfg_we = 1'b0; cfg_idx = 2'd0; cfg_en = 1'b0; cfg_match = 32'd0; cfg_mask = 32'd0;
      instr_vld = 1'b0; instr = 32'd0; pc = 32'd0;
      csr_mstatus = 32'h00001800; csr_mtvec = 32'h00000100; csr_mcycle = 64'd0;
      log_rdy = 1'b0;

      // reset state
      #3;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_vld", 64'(log_vld), 64'd0);
      chk("rst_ovf", 64'(ovf_cnt), 64'd0);
      chk("rst_pc", 64'(log_pc), 64'd0);
      #9 rst = 1'b0;
      cyc();

      // 1: SUB trigger, one-cycle record, ADD ignored
      cfg(2'd0, 1'b1, SUB_M, SUB_K);
      ctrl_arm = 1'b1; cyc(); ctrl_arm = 1'b0;
      chk("arm_state", 64'(state), 64'd1);
      log_rdy = 1'b1;
      issue(SUB_I, 32'h200, 64'h1F);
      chk("t1_vld", 64'(log_vld), 64'd1);
      chk("t1_id", 64'(log_trig_id), 64'd0);
      chk("t1_pc", 64'(log_pc), 64'h200);
      chk("t1_instr", 64'(log_instr), 64'(SUB_I));
      chk("t1_mcycle", log_mcycle, 64'h1F);
      chk("t1_mstatus", 64'(log_mstatus), 64'h1800);
      chk("t1_mtvec", 64'(log_mtvec), 64'h100);
      cyc();
      chk("t1_one_cycle", 64'(log_vld), 64'd0);
      issue(ADD_I, 32'h204, 64'h20);
      chk("t1_add_nohit", 64'(log_vld), 64'd0);

      // 2: priority between SUB trigger 0 and match-all trigger 1
      cfg(2'd1, 1'b1, 32'd0, 32'd0);
      issue(SUB_I, 32'h208, 64'h30);
      chk("t2_sub_id", 64'(log_trig_id), 64'd0);
      chk("t2_sub_vld", 64'(log_vld), 64'd1);
      issue(ADD_I, 32'h20C, 64'h31);
      chk("t2_add_vld", 64'(log_vld), 64'd1);
      chk("t2_add_id", 64'(log_trig_id), 64'd1);
      chk("t2_add_pc", 64'(log_pc), 64'h20C);
      cyc();
      chk("t2_single", 64'(log_vld), 64'd0);

      // 3: ten captures into eight slots with the sink stalled
      log_rdy = 1'b0;
      for (int k = 0; k < 10; k++) begin
         instr_vld = 1'b1; instr = ADD_I; pc = 32'h1000 + 32'(4 * k);
         csr_mcycle = 64'h1_0000_0000 + 64'(k);
         cyc();
      end
      instr_vld = 1'b0;
      chk("t3_ovf", 64'(ovf_cnt), 64'd2);
      chk("t3_head_pc", 64'(log_pc), 64'h1000);
      chk("t3_head_mcycle", log_mcycle, 64'h1_0000_0000);
      cyc();
      chk("t3_stable_pc", 64'(log_pc), 64'h1000);

      // 4: full FIFO, pop and hit together
      log_rdy = 1'b1;
      issue(ADD_I, 32'h2000, 64'h55);
      chk("t4_ovf", 64'(ovf_cnt), 64'd2);
      for (int k = 1; k < 8; k++) begin
         chk("t4_drain_pc", 64'(log_pc), 64'(32'h1000 + 32'(4 * k)));
         cyc();
      end
      chk("t4_last_pc", 64'(log_pc), 64'h2000);
      chk("t4_last_vld", 64'(log_vld), 64'd1);
      cyc();
      chk("t4_empty", 64'(log_vld), 64'd0);

      // 5: stop with a matching instruction, flush, re-arm clears ovf
      log_rdy = 1'b0;
      issue(ADD_I, 32'h300, 64'h60);
      issue(ADD_I, 32'h304, 64'h61);
      issue(ADD_I, 32'h308, 64'h62);
      instr_vld = 1'b1; instr = ADD_I; pc = 32'h30C; ctrl_stop = 1'b1; ctrl_arm = 1'b1;
      cyc();
      instr_vld = 1'b0; ctrl_stop = 1'b0;
      chk("t5_flush", 64'(state), 64'd2);
      cyc();
      ctrl_arm = 1'b0;
      chk("t5_arm_ignored", 64'(state), 64'd2);
      log_rdy = 1'b1;
      chk("t5_pc0", 64'(log_pc), 64'h300);
      cyc();
      chk("t5_pc1", 64'(log_pc), 64'h304);
      chk("t5_still_flush", 64'(state), 64'd2);
      cyc();
      chk("t5_pc2", 64'(log_pc), 64'h308);
      cyc();
      chk("t5_disabled", 64'(state), 64'd0);
      chk("t5_no_extra", 64'(log_vld), 64'd0);
      chk("t5_ovf_kept", 64'(ovf_cnt), 64'd2);
      ctrl_arm = 1'b1; cyc(); ctrl_arm = 1'b0;
      chk("t5_rearm", 64'(state), 64'd1);
      chk("t5_ovf_clr", 64'(ovf_cnt), 64'd0);

      // 6: asynchronous reset mid-drain clears everything, config included
      log_rdy = 1'b0;
      for (int k = 0; k < 10; k++) begin
         issue(ADD_I, 32'h500 + 32'(4 * k), 64'h70);
      end
      chk("t6_pre_ovf", 64'(ovf_cnt), 64'd2);
      log_rdy = 1'b1;
      cyc();
      chk("t6_pre_vld", 64'(log_vld), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("t6_vld", 64'(log_vld), 64'd0);
      chk("t6_state", 64'(state), 64'd0);
      chk("t6_ovf", 64'(ovf_cnt), 64'd0);
      chk("t6_pc", 64'(log_pc), 64'd0);
      chk("t6_mcycle", log_mcycle, 64'd0);
      #5 rst = 1'b0;
      cyc();
      ctrl_arm = 1'b1; ctrl_stop = 1'b1; cyc(); ctrl_arm = 1'b0; ctrl_stop = 1'b0;
      chk("t6_both_arm", 64'(state), 64'd1);
      issue(SUB_I, 32'h600, 64'h80);
      chk("t6_cfg_cleared", 64'(log_vld), 64'd0);

      // config write racing a compare uses the old value
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_en = 1'b1; cfg_match = 32'd0; cfg_mask = 32'd0;
      instr_vld = 1'b1; instr = ADD_I; pc = 32'h400; csr_mcycle = 64'h90;
      cyc();
      cfg_we = 1'b0;
      chk("cfg_old_value", 64'(log_vld), 64'd0);
      instr_vld = 1'b1; pc = 32'h404; csr_mcycle = 64'h91;
      cyc();
      instr_vld = 1'b0;
      chk("cfg_new_vld", 64'(log_vld), 64'd1);
      chk("cfg_new_id", 64'(log_trig_id), 64'd0);
      chk("cfg_new_pc", 64'(log_pc), 64'h404);
      cyc();
      chk("cfg_drained", 64'(log_vld), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
